mpi_bus_master: RTL and testbench



---
 rtl/mpi_bus_master.sv | 137 +++++++++++++
 tb/tb_mpi_bus_master.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_bus_master.sv
// mpi_bus_master: registered MPI/Q-bus master sequencer.
// Drives SYNC/DIN/DOUT phases, reply timeout and DMA handoff.
module mpi_bus_master #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TO_W    = 6,
   parameter int TIMEOUT = 63
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ce,
   input  logic          req_rd,
   input  logic          req_wr,
   input  logic          req_byte,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          bsync,
   output logic          bdin,
   output logic          bdout,
   output logic          bwtbt,
   output logic          bbsy,
   output logic [AW-1:0] bda,
   output logic [DW-1:0] bdo,
   input  logic          breply,
   input  logic [DW-1:0] bdi,
   input  logic          dmr,
   output logic          dmgo,
   input  logic          sack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE,
      S_ERR,
      S_GRANT,
      S_DMA
   } state_t;

   state_t          state;
   logic [TO_W-1:0] timer;
   logic            rd_cyc;

   // Sequencer: state, reply timer and every registered bus output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         timer  <= '0;
         rd_cyc <= 1'b0;
         rdata  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         bsync  <= 1'b0;
         bdin   <= 1'b0;
         bdout  <= 1'b0;
         bwtbt  <= 1'b0;
         bbsy   <= 1'b0;
         bda    <= '0;
         bdo    <= '0;
         dmgo   <= 1'b0;
      end else if (ce) begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (dmr) begin
                  state <= S_GRANT;
                  dmgo  <= 1'b1;
               end else if ((req_rd || req_wr) && !breply) begin
                  state  <= S_ADDR;
                  rd_cyc <= req_rd;
                  busy   <= 1'b1;
                  bsync  <= 1'b1;
                  bbsy   <= 1'b1;
                  bwtbt  <= req_byte;
                  bda    <= req_addr;
                  bdo    <= req_rd ? '0 : req_wdata;
               end
            end
            S_ADDR: begin
               state <= S_DATA;
               timer <= TO_W'(TIMEOUT);
               bdin  <= rd_cyc;
               bdout <= !rd_cyc;
            end
            S_DATA: begin
               if (breply || timer == '0) begin
                  state <= breply ? S_DONE : S_ERR;
                  done  <= breply;
                  err   <= !breply;
                  if (breply && rd_cyc)
                     rdata <= bdi;
                  busy  <= 1'b0;
                  bsync <= 1'b0;
                  bbsy  <= 1'b0;
                  bdin  <= 1'b0;
                  bdout <= 1'b0;
                  bwtbt <= 1'b0;
                  bda   <= '0;
                  bdo   <= '0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            S_ERR: begin
               state <= S_IDLE;
            end
            S_GRANT: begin
               if (sack) begin
                  state <= S_DMA;
                  dmgo  <= 1'b0;
               end else if (!dmr) begin
                  state <= S_IDLE;
                  dmgo  <= 1'b0;
               end
            end
            S_DMA: begin
               if (!sack)
                  state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpi_bus_master.sv
// tb_mpi_bus_master: vectors, corner sequences and random
// transactions against an offset-based bus cycle model.
module tb_mpi_bus_master;
   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int TO_W    = 6;
   localparam int TIMEOUT = 63;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          ce = 1'b0;
   logic          req_rd = 1'b0;
   logic          req_wr = 1'b0;
   logic          req_byte = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [DW-1:0] rdata;
   logic          busy, done, err;
   logic          bsync, bdin, bdout, bwtbt, bbsy;
   logic [AW-1:0] bda;
   logic [DW-1:0] bdo;
   logic          breply = 1'b0;
   logic [DW-1:0] bdi = '0;
   logic          dmr = 1'b0;
   logic          dmgo;
   logic          sack = 1'b0;

   mpi_bus_master #(
      .AW(AW), .DW(DW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce),
      .req_rd(req_rd), .req_wr(req_wr), .req_byte(req_byte),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rdata(rdata), .busy(busy), .done(done), .err(err),
      .bsync(bsync), .bdin(bdin), .bdout(bdout), .bwtbt(bwtbt),
      .bbsy(bbsy), .bda(bda), .bdo(bdo),
      .breply(breply), .bdi(bdi),
      .dmr(dmr), .dmgo(dmgo), .sack(sack)
   );

   always #5 clk = ~clk;

   int clk_cnt = 0;
   always @(posedge clk) clk_cnt <= clk_cnt + 1;

   typedef logic [56:0] ov_t;

   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] m_rdata = '0;
   ov_t           exp_cur;
   int            stall_mode = 0;
   int            c_bsync, c_strobe, c_done, c_err, done_lat;

   function automatic ov_t pack_dut();
      return {rdata, busy, done, err, bsync, bdin, bdout,
              bwtbt, bbsy, bda, bdo, dmgo};
   endfunction

   // expected outputs: busy/bbsy follow bsync on this bus
   function automatic ov_t mk(logic bs, logic di, logic dout,
                              logic bw, logic [AW-1:0] a,
                              logic [DW-1:0] d, logic dn,
                              logic er, logic dg);
      return {m_rdata, bs, dn, er, bs, di, dout, bw, bs, a, d, dg};
   endfunction

   function automatic ov_t idle_o();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic check(input string nm, input ov_t act, input ov_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // one ce edge, optionally preceded by ce=0 clocks that must freeze
   task automatic tick();
      int n;
      if (stall_mode == 0) n = 0;
      else if (stall_mode == 1) n = 1;
      else n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         ce = 1'b0;
         @(posedge clk);
         #1;
         check("frozen", pack_dut(), exp_cur);
      end
      ce = 1'b1;
      @(posedge clk);
      #1;
      ce = 1'b0;
   endtask

   // whole bus cycle; w = ce periods of DATA before reply,
   // w > TIMEOUT means the slave never replies
   task automatic run_txn(input logic rd, input logic byt,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] wd,
                          input logic [DW-1:0] rv, input int w);
      bit tmo;
      int endj;
      int t0;
      tmo = (w > TIMEOUT);
      endj = tmo ? TIMEOUT + 2 : w + 2;
      c_bsync = 0;
      c_strobe = 0;
      c_done = 0;
      c_err = 0;
      done_lat = -1;
      t0 = 0;
      exp_cur = idle_o();
      req_rd = rd;
      req_wr = !rd;
      req_byte = byt;
      req_addr = a;
      req_wdata = wd;
      for (int j = 0; j <= endj + 1; j++) begin
         breply = !tmo && (j == w + 2);
         bdi = breply ? rv : DW'($urandom);
         tick();
         if (j == 0) begin
            t0 = clk_cnt;
            req_rd = 1'b0;
            req_wr = 1'b0;
            req_addr = AW'($urandom);
            req_wdata = DW'($urandom);
            req_byte = 1'($urandom);
         end
         if (j == endj && !tmo && rd) m_rdata = rv;
         if (j < endj)
            exp_cur = mk(1'b1, rd && j > 0, !rd && j > 0, byt, a,
                         rd ? {DW{1'b0}} : wd, 1'b0, 1'b0, 1'b0);
         else if (j == endj)
            exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0,
                         !tmo, tmo, 1'b0);
         else
            exp_cur = idle_o();
         check($sformatf("txn a=%o j=%0d", a, j), pack_dut(), exp_cur);
         if (bsync) c_bsync++;
         if (bdin || bdout) c_strobe++;
         if (done) c_done++;
         if (err) c_err++;
         if (done && done_lat < 0) done_lat = clk_cnt - t0;
      end
      breply = 1'b0;
   endtask

   typedef struct {
      logic          rd;
      logic          byt;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [DW-1:0] rv;
      int            w;
      int            stall;
      logic [DW-1:0] e_rdata;
      int            e_bsync;
      int            e_strobe;
      int            e_done;
      int            e_err;
      int            e_lat;
   } vec_t;

   vec_t vt[8];

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b1, 1'b0, 16'o177716, 16'o000000, 16'o123456, 1, 0,
                16'o123456, 3, 2, 1, 0, 3};
      vt[1] = '{1'b0, 1'b1, 16'o001001, 16'o000377, 16'o000000, 0, 0,
                16'o123456, 2, 1, 1, 0, 2};
      vt[2] = '{1'b1, 1'b0, 16'o000100, 16'o000000, 16'o111111, 64, 0,
                16'o123456, 65, 64, 0, 1, -1};
      vt[3] = '{1'b0, 1'b0, 16'o000200, 16'o052525, 16'o000000, 5, 0,
                16'o123456, 7, 6, 1, 0, 7};
      vt[4] = '{1'b1, 1'b0, 16'o000202, 16'o000000, 16'o007007, 63, 0,
                16'o007007, 65, 64, 1, 0, 65};
      vt[5] = '{1'b1, 1'b1, 16'o000203, 16'o000000, 16'o000077, 0, 0,
                16'o000077, 2, 1, 1, 0, 2};
      vt[6] = '{1'b1, 1'b0, 16'o177560, 16'o000000, 16'o054321, 1, 1,
                16'o054321, 3, 2, 1, 0, 6};
      vt[7] = '{1'b0, 1'b0, 16'o177566, 16'o000101, 16'o000000, 0, 1,
                16'o054321, 2, 1, 1, 0, 4};

      // reset state, with ce and a request active
      #2;
      reset_n = 1'b0;
      #1;
      check("reset async", pack_dut(), idle_o());
      ce = 1'b1;
      req_rd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset held", pack_dut(), idle_o());
      req_rd = 1'b0;
      ce = 1'b0;
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cur = idle_o();

      // directed vectors
      for (int i = 0; i < 8; i++) begin
         stall_mode = vt[i].stall;
         run_txn(vt[i].rd, vt[i].byt, vt[i].a, vt[i].wd,
                 vt[i].rv, vt[i].w);
         check_int($sformatf("v%0d rdata", i), int'(rdata),
                   int'(vt[i].e_rdata));
         check_int($sformatf("v%0d bsync", i), c_bsync, vt[i].e_bsync);
         check_int($sformatf("v%0d strobe", i), c_strobe, vt[i].e_strobe);
         check_int($sformatf("v%0d done", i), c_done, vt[i].e_done);
         check_int($sformatf("v%0d err", i), c_err, vt[i].e_err);
         check_int($sformatf("v%0d lat", i), done_lat, vt[i].e_lat);
      end
      stall_mode = 0;

      // DMA wins over a simultaneous read, then the read runs
      dmr = 1'b1;
      req_rd = 1'b1;
      req_addr = 16'o000500;
      tick();
      exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("dma grant", pack_dut(), exp_cur);
      tick();
      check("dma grant hold", pack_dut(), exp_cur);
      sack = 1'b1;
      tick();
      exp_cur = idle_o();
      check("dma sack", pack_dut(), exp_cur);
      dmr = 1'b0;
      tick();
      check("dma holds off req", pack_dut(), exp_cur);
      sack = 1'b0;
      tick();
      check("dma release", pack_dut(), exp_cur);
      run_txn(1'b1, 1'b0, 16'o000500, 16'o0, 16'o070707, 2);
      check_int("dma then read", int'(rdata), int'(16'o070707));

      // grant withdrawn before sack returns to IDLE
      dmr = 1'b1;
      tick();
      exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("grant offer", pack_dut(), exp_cur);
      dmr = 1'b0;
      tick();
      exp_cur = idle_o();
      check("grant withdrawn", pack_dut(), exp_cur);
      run_txn(1'b0, 1'b0, 16'o000520, 16'o000777, 16'o0, 1);
      check_int("withdraw then write", c_done, 1);

      // reply held after done blocks the next cycle
      req_wr = 1'b1;
      req_addr = 16'o000600;
      req_wdata = 16'o000001;
      req_byte = 1'b0;
      tick();
      exp_cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'o000600, 16'o000001,
                   1'b0, 1'b0, 1'b0);
      check("hold addr", pack_dut(), exp_cur);
      tick();
      exp_cur = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'o000600, 16'o000001,
                   1'b0, 1'b0, 1'b0);
      check("hold data", pack_dut(), exp_cur);
      breply = 1'b1;
      tick();
      exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("hold done", pack_dut(), exp_cur);
      exp_cur = idle_o();
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold wait %0d", i), pack_dut(), exp_cur);
      end
      breply = 1'b0;
      tick();
      exp_cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'o000600, 16'o000001,
                   1'b0, 1'b0, 1'b0);
      check("hold restart", pack_dut(), exp_cur);
      req_wr = 1'b0;
      tick();
      exp_cur = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'o000600, 16'o000001,
                   1'b0, 1'b0, 1'b0);
      check("restart data", pack_dut(), exp_cur);
      breply = 1'b1;
      tick();
      exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      check("restart done", pack_dut(), exp_cur);
      breply = 1'b0;
      tick();
      exp_cur = idle_o();
      check("restart idle", pack_dut(), exp_cur);

      // reset in the middle of a data phase
      req_rd = 1'b1;
      req_addr = 16'o000700;
      tick();
      tick();
      req_rd = 1'b0;
      exp_cur = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'o000700, '0,
                   1'b0, 1'b0, 1'b0);
      check("pre reset data", pack_dut(), exp_cur);
      #2;
      reset_n = 1'b0;
      #1;
      m_rdata = '0;
      exp_cur = idle_o();
      check("reset mid data", pack_dut(), exp_cur);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      run_txn(1'b1, 1'b0, 16'o000702, 16'o0, 16'o135135, 1);
      check_int("post reset read", int'(rdata), int'(16'o135135));

      // random transactions with random ce stalls
      for (int i = 0; i < 24; i++) begin
         int w;
         stall_mode = $urandom_range(0, 2);
         w = ($urandom_range(0, 11) == 0) ? TIMEOUT + 1
                                           : $urandom_range(0, 6);
         run_txn(1'($urandom), 1'($urandom), AW'($urandom),
                 DW'($urandom), DW'($urandom), w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
